// File: rtl/axi4_lite_pkg.sv
// Shared definitions for the AXI4-Lite register-file slave.
//   RESP_OKAY / RESP_SLVERR : AXI response codes driven on BRESP / RRESP
//   clog2()                 : constant ceil(log2) used to size address
//                             decode fields (byte-lane LSBs, index width)
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/axi4_lite_strb_merge.sv
// Byte-lane merge for a register write.
//   old_data : current register contents
//   wdata    : incoming AXI write data
//   wstrb    : one enable per byte lane; 1 takes the byte from wdata
//   merged   : resulting register value
module axi4_lite_strb_merge #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0]   old_data,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  output logic [DATA_WIDTH-1:0]   merged
);

  always_comb begin
    merged = old_data;
    for (int b = 0; b < DATA_WIDTH / 8; b++) begin
      if (wstrb[b]) merged[8*b +: 8] = wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave in front of a register file of NUM_REGS words.
//   iCLK, iRST         : clock, asynchronous active-low reset
//   s_AW* / s_W* / s_B*: write address, write data, write response channels
//   s_AR* / s_R*       : read address and read data channels
//   iRO_DATA           : read values of read-only slots (word i at i*DATA_WIDTH)
//   oREGS              : flat view of all writable registers (read-only slots 0)
//
// Handshake semantics (all channels): a transfer happens on the rising edge
// where VALID and READY are both 1. A source keeps VALID and its payload
// stable until that edge. Here every READY depends only on internal state,
// never combinationally on the matching VALID, and BVALID/RVALID with their
// payloads hold until the master's BREADY/RREADY completes the transfer.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0]   RO_MASK    = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                           iCLK,
  input  logic                           iRST,
  input  logic                           s_AWVALID,
  output logic                           s_AWREADY,
  input  logic [ADDR_WIDTH-1:0]          s_AWADDR,
  input  logic                           s_WVALID,
  output logic                           s_WREADY,
  input  logic [DATA_WIDTH-1:0]          s_WDATA,
  input  logic [DATA_WIDTH/8-1:0]        s_WSTRB,
  output logic                           s_BVALID,
  input  logic                           s_BREADY,
  output logic [1:0]                     s_BRESP,
  input  logic                           s_ARVALID,
  output logic                           s_ARREADY,
  input  logic [ADDR_WIDTH-1:0]          s_ARADDR,
  output logic                           s_RVALID,
  input  logic                           s_RREADY,
  output logic [DATA_WIDTH-1:0]          s_RDATA,
  output logic [1:0]                     s_RRESP,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] iRO_DATA,
  output logic [NUM_REGS*DATA_WIDTH-1:0] oREGS
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = clog2(STRB_W);
  localparam int IDX_W  = clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] NUM_REGS_A = ADDR_WIDTH'(NUM_REGS);

  // Register storage views: reg_word is the writable contents (0 for
  // read-only slots), ro_word the fabric-supplied read-only values.
  logic [DATA_WIDTH-1:0] reg_word [NUM_REGS];
  logic [DATA_WIDTH-1:0] ro_word  [NUM_REGS];

  // ---------------------------------------------------------------- write
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_W-1:0]     w_strb_q;

  logic                  aw_fire, w_fire, commit;
  logic [ADDR_WIDTH-1:0] wr_addr, wr_word_addr;
  logic [DATA_WIDTH-1:0] wr_data, wr_old, wr_merged;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      wr_idx;
  logic                  wr_in_range, wr_ok, wr_en;

  assign s_AWREADY = !aw_held && !s_BVALID;
  assign s_WREADY  = !w_held  && !s_BVALID;
  assign aw_fire   = s_AWVALID && s_AWREADY;
  assign w_fire    = s_WVALID  && s_WREADY;

  // A channel counts as available if already held or handshaking this edge,
  // so a write commits on the very edge its second half arrives.
  assign commit  = (aw_held || aw_fire) && (w_held || w_fire);
  assign wr_addr = aw_held ? aw_addr_q : s_AWADDR;
  assign wr_data = w_held  ? w_data_q  : s_WDATA;
  assign wr_strb = w_held  ? w_strb_q  : s_WSTRB;

  // Full-width compare so high address bits beyond the index still decode
  // as out of range instead of aliasing onto a low register.
  assign wr_word_addr = wr_addr >> LSB;
  assign wr_in_range  = wr_word_addr < NUM_REGS_A;
  assign wr_idx       = wr_word_addr[IDX_W-1:0];
  assign wr_ok        = wr_in_range && !RO_MASK[wr_idx];
  assign wr_en        = commit && wr_ok;
  assign wr_old       = wr_in_range ? reg_word[wr_idx] : '0;

  axi4_lite_strb_merge #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_strb_merge (
    .old_data (wr_old),
    .wdata    (wr_data),
    .wstrb    (wr_strb),
    .merged   (wr_merged)
  );

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_fire) aw_addr_q <= s_AWADDR;
      if (w_fire) begin
        w_data_q <= s_WDATA;
        w_strb_q <= s_WSTRB;
      end
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end else begin
        if (aw_fire) aw_held <= 1'b1;
        if (w_fire)  w_held  <= 1'b1;
      end
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s_BVALID <= 1'b0;
      s_BRESP  <= RESP_OKAY;
    end else if (commit) begin
      s_BVALID <= 1'b1;
      s_BRESP  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else if (s_BVALID && s_BREADY) begin
      s_BVALID <= 1'b0;
      s_BRESP  <= RESP_OKAY;
    end
  end

  // ------------------------------------------------------------ registers
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    assign ro_word[i] = iRO_DATA[i*DATA_WIDTH +: DATA_WIDTH];

    if (RO_MASK[i]) begin : g_ro
      assign reg_word[i] = '0;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) q <= RESET_VAL;
        else if (wr_en && wr_idx == IDX_W'(i)) q <= wr_merged;
      end
      assign reg_word[i] = q;
    end

    assign oREGS[i*DATA_WIDTH +: DATA_WIDTH] = reg_word[i];
  end

  // ----------------------------------------------------------------- read
  logic                  ar_fire;
  logic [ADDR_WIDTH-1:0] rd_word_addr;
  logic [IDX_W-1:0]      rd_idx;
  logic                  rd_in_range;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [1:0]            rd_resp;

  assign s_ARREADY    = !s_RVALID;
  assign ar_fire      = s_ARVALID && s_ARREADY;
  assign rd_word_addr = s_ARADDR >> LSB;
  assign rd_in_range  = rd_word_addr < NUM_REGS_A;
  assign rd_idx       = rd_word_addr[IDX_W-1:0];

  // Reads see the register value before any write committing on the same
  // edge, since reg_word is the flop output.
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_in_range) begin
      rd_resp = RESP_OKAY;
      rd_data = RO_MASK[rd_idx] ? ro_word[rd_idx] : reg_word[rd_idx];
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      s_RVALID <= 1'b0;
      s_RDATA  <= '0;
      s_RRESP  <= RESP_OKAY;
    end else if (ar_fire) begin
      s_RVALID <= 1'b1;
      s_RDATA  <= rd_data;
      s_RRESP  <= rd_resp;
    end else if (s_RVALID && s_RREADY) begin
      s_RVALID <= 1'b0;
      s_RDATA  <= '0;
      s_RRESP  <= RESP_OKAY;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench for axi4_lite_regfile_slave (32-bit data, 16 registers,
// register 3 read-only). A behavioural model holds the expected register
// contents; all stimulus changes on the falling edge and all sampling is
// done on the falling edge, away from the active rising edge.
module tb_axi4_lite_regfile_slave;

  localparam int          NREG      = 16;
  localparam logic [15:0] RO_MASK   = 16'h0008;
  localparam logic [31:0] RESET_VAL = 32'h1357_9BDF;

  // ---------------------------------------------------- clock and reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        aw_valid = 0, w_valid = 0, b_ready = 0, ar_valid = 0, r_ready = 0;
  logic [31:0] aw_addr = 0, w_data = 0, ar_addr = 0;
  logic [3:0]  w_strb = 0;
  logic        aw_ready, w_ready, b_valid, ar_ready, r_valid;
  logic [1:0]  b_resp, r_resp;
  logic [31:0] r_data;
  logic [NREG*32-1:0] ro_bus, regs_bus;

  logic [31:0] ro_data  [NREG];
  logic [31:0] exp_regs [NREG];
  logic [31:0] exp_q [$];
  logic [1:0]  exp_resp_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  always_comb begin
    ro_bus = '0;
    for (int i = 0; i < NREG; i++) ro_bus[i*32 +: 32] = ro_data[i];
  end

  axi4_lite_regfile_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .NUM_REGS   (NREG),
    .RO_MASK    (RO_MASK),
    .RESET_VAL  (RESET_VAL)
  ) dut (
    .iCLK      (clk),
    .iRST      (rst_n),
    .s_AWVALID (aw_valid),
    .s_AWREADY (aw_ready),
    .s_AWADDR  (aw_addr),
    .s_WVALID  (w_valid),
    .s_WREADY  (w_ready),
    .s_WDATA   (w_data),
    .s_WSTRB   (w_strb),
    .s_BVALID  (b_valid),
    .s_BREADY  (b_ready),
    .s_BRESP   (b_resp),
    .s_ARVALID (ar_valid),
    .s_ARREADY (ar_ready),
    .s_ARADDR  (ar_addr),
    .s_RVALID  (r_valid),
    .s_RREADY  (r_ready),
    .s_RDATA   (r_data),
    .s_RRESP   (r_resp),
    .iRO_DATA  (ro_bus),
    .oREGS     (regs_bus)
  );

  // ------------------------------------------------------ reference model
  function automatic logic [31:0] model_word(input int i);
    return RO_MASK[i] ? 32'h0 : exp_regs[i];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREG; i++) exp_regs[i] = RESET_VAL;
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
    logic [31:0] idx;
    idx = addr / 4;
    if (idx >= NREG || RO_MASK[idx[3:0]]) begin
      resp = 2'b10;
    end else begin
      resp = 2'b00;
      for (int b = 0; b < 4; b++)
        if (strb[b]) exp_regs[idx[3:0]][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  task automatic model_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
    logic [31:0] idx;
    idx = addr / 4;
    if (idx >= NREG) begin
      data = 32'h0;
      resp = 2'b10;
    end else begin
      data = RO_MASK[idx[3:0]] ? ro_data[idx[3:0]] : exp_regs[idx[3:0]];
      resp = 2'b00;
    end
  endtask

  // --------------------------------------------------------------- drivers
  // All drivers are entered and left on a falling edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output bit timed_out);
    bit aw_done = 0, w_done = 0, aw_go, w_go, b_go;
    timed_out = 1;
    resp = 2'bxx;
    b_ready = 1;
    for (int c = 0; c < 40; c++) begin
      aw_valid = !aw_done && c >= aw_dly;
      aw_addr  = addr;
      w_valid  = !w_done && c >= w_dly;
      w_data   = data;
      w_strb   = strb;
      aw_go = aw_valid && aw_ready;
      w_go  = w_valid && w_ready;
      b_go  = b_valid && b_ready;
      if (b_go) resp = b_resp;
      @(posedge clk);
      @(negedge clk);
      if (aw_go) aw_done = 1;
      if (w_go)  w_done  = 1;
      if (b_go) begin
        timed_out = 0;
        break;
      end
    end
    aw_valid = 0;
    w_valid  = 0;
    b_ready  = 0;
  endtask

  task automatic do_read(input logic [31:0] addr, output logic [31:0] data,
                         output logic [1:0] resp, output bit timed_out);
    bit ar_done = 0, ar_go, r_go;
    timed_out = 1;
    data = 'x;
    resp = 2'bxx;
    r_ready = 1;
    for (int c = 0; c < 20; c++) begin
      ar_valid = !ar_done;
      ar_addr  = addr;
      ar_go = ar_valid && ar_ready;
      r_go  = r_valid && r_ready;
      if (r_go) begin
        data = r_data;
        resp = r_resp;
      end
      @(posedge clk);
      @(negedge clk);
      if (ar_go) ar_done = 1;
      if (r_go) begin
        timed_out = 0;
        break;
      end
    end
    ar_valid = 0;
    r_ready  = 0;
  endtask

  // ----------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    model_reset();
    n_checks++;
    if ({b_valid, r_valid, b_resp, r_resp} !== 6'b0) begin
      n_fail++;
      $display("FAIL reset_status: got bv=%b rv=%b bresp=%b rresp=%b expected all 0",
               b_valid, r_valid, b_resp, r_resp);
    end
    n_checks++;
    if (r_data !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_rdata: got %h expected 0", r_data);
    end
    n_checks++;
    if ({aw_ready, w_ready, ar_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL reset_ready: got aw/w/ar=%b expected 111", {aw_ready, w_ready, ar_ready});
    end
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (regs_bus[i*32 +: 32] !== model_word(i)) begin
        n_fail++;
        $display("FAIL reset_reg%0d: got %h expected %h", i, regs_bus[i*32 +: 32], model_word(i));
      end
    end
  endtask

  task automatic test_basic();
    logic [1:0] resp, mresp;
    logic [31:0] data;
    bit to;
    aw_valid = 1; aw_addr = 32'h4;
    w_valid = 1; w_data = 32'hDEADBEEF; w_strb = 4'hF;
    b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
    model_write(32'h4, 32'hDEADBEEF, 4'hF, mresp);
    n_checks++;
    if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_bvalid: got bv=%b bresp=%b expected 1/00", b_valid, b_resp);
    end
    n_checks++;
    if (regs_bus[32 +: 32] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL basic_reg1: got %h expected deadbeef", regs_bus[32 +: 32]);
    end
    @(posedge clk);
    @(negedge clk);
    b_ready = 0;
    n_checks++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_bclear: got bv=%b awready=%b expected 0/1", b_valid, aw_ready);
    end
    do_read(32'h4, data, resp, to);
    n_checks++;
    if (to || data !== 32'hDEADBEEF || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL basic_read: got %h resp %b timeout %0d expected deadbeef/00", data, resp, to);
    end
  endtask

  task automatic test_w_first();
    logic [1:0] resp;
    bit to;
    do_write(32'h8, 32'hAAAAAAAA, 4'hF, 0, 0, resp, to);
    model_write(32'h8, 32'hAAAAAAAA, 4'hF, resp);
    w_valid = 1; w_data = 32'h11223344; w_strb = 4'b0101;
    @(posedge clk);
    @(negedge clk);
    w_valid = 0;
    n_checks++;
    if (w_ready !== 1'b0 || b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wfirst_hold: got wready=%b bvalid=%b expected 0/0", w_ready, b_valid);
    end
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    aw_valid = 1; aw_addr = 32'h8; b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0;
    model_write(32'h8, 32'h11223344, 4'b0101, resp);
    n_checks++;
    if (b_valid !== 1'b1 || b_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL wfirst_resp: got bv=%b bresp=%b expected 1/00", b_valid, b_resp);
    end
    n_checks++;
    if (regs_bus[64 +: 32] !== 32'hAA22AA44 || exp_regs[2] !== 32'hAA22AA44) begin
      n_fail++;
      $display("FAIL wfirst_reg2: got %h expected aa22aa44", regs_bus[64 +: 32]);
    end
    @(posedge clk);
    @(negedge clk);
    b_ready = 0;
  endtask

  task automatic test_read_only();
    logic [1:0] resp;
    logic [31:0] data;
    bit to;
    ro_data[3] = 32'hCAFEF00D;
    do_write(32'hC, 32'h12345678, 4'hF, 1, 0, resp, to);
    n_checks++;
    if (to || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL ro_write_resp: got %b timeout %0d expected 10", resp, to);
    end
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (regs_bus[i*32 +: 32] !== model_word(i)) begin
        n_fail++;
        $display("FAIL ro_write_reg%0d: got %h expected %h", i, regs_bus[i*32 +: 32], model_word(i));
      end
    end
    do_read(32'hC, data, resp, to);
    n_checks++;
    if (to || data !== 32'hCAFEF00D || resp !== 2'b00) begin
      n_fail++;
      $display("FAIL ro_read: got %h resp %b expected cafef00d/00", data, resp);
    end
  endtask

  task automatic test_decode_error();
    logic [1:0] resp;
    logic [31:0] data;
    bit to;
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, 2, resp, to);
    n_checks++;
    if (to || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL decerr_write_resp: got %b timeout %0d expected 10", resp, to);
    end
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (regs_bus[i*32 +: 32] !== model_word(i)) begin
        n_fail++;
        $display("FAIL decerr_reg%0d: got %h expected %h", i, regs_bus[i*32 +: 32], model_word(i));
      end
    end
    do_read(32'h40, data, resp, to);
    n_checks++;
    if (to || data !== 32'h0 || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL decerr_read: got %h resp %b expected 0/10", data, resp);
    end
    do_read(32'h8000_0004, data, resp, to);
    n_checks++;
    if (to || data !== 32'h0 || resp !== 2'b10) begin
      n_fail++;
      $display("FAIL decerr_read_high: got %h resp %b expected 0/10", data, resp);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_d;
    logic [1:0] exp_r;
    aw_valid = 1; aw_addr = 32'h44; w_valid = 1; w_data = 32'h5555_5555; w_strb = 4'hF;
    b_ready = 0;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0; w_valid = 0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (b_valid !== 1'b1 || b_resp !== 2'b10 || aw_ready !== 1'b0 || w_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_write_c%0d: got bv=%b bresp=%b awr=%b wr=%b expected 1/10/0/0",
                 c, b_valid, b_resp, aw_ready, w_ready);
      end
      @(posedge clk);
      @(negedge clk);
    end
    b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    b_ready = 0;
    n_checks++;
    if (b_valid !== 1'b0 || aw_ready !== 1'b1 || w_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_write_release: got bv=%b awr=%b wr=%b expected 0/1/1", b_valid, aw_ready, w_ready);
    end
    model_read(32'h4, exp_d, exp_r);
    ar_valid = 1; ar_addr = 32'h4; r_ready = 0;
    @(posedge clk);
    @(negedge clk);
    ar_valid = 0;
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if (r_valid !== 1'b1 || r_data !== exp_d || r_resp !== exp_r || ar_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_read_c%0d: got rv=%b %h resp %b arr=%b expected 1/%h/%b/0",
                 c, r_valid, r_data, r_resp, ar_ready, exp_d, exp_r);
      end
      @(posedge clk);
      @(negedge clk);
    end
    r_ready = 1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 0;
    n_checks++;
    if (r_valid !== 1'b0 || ar_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_read_release: got rv=%b arr=%b expected 0/1", r_valid, ar_ready);
    end
  endtask

  task automatic test_same_edge();
    logic [31:0] old_d, new_d;
    logic [1:0] mresp;
    old_d = exp_regs[5];
    new_d = $urandom;
    aw_valid = 1; aw_addr = 32'h14; w_valid = 1; w_data = new_d; w_strb = 4'hF; b_ready = 1;
    ar_valid = 1; ar_addr = 32'h14; r_ready = 0;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0; w_valid = 0; ar_valid = 0;
    model_write(32'h14, new_d, 4'hF, mresp);
    n_checks++;
    if (r_valid !== 1'b1 || r_data !== old_d) begin
      n_fail++;
      $display("FAIL same_edge_rdata: got rv=%b %h expected 1/%h", r_valid, r_data, old_d);
    end
    n_checks++;
    if (regs_bus[5*32 +: 32] !== exp_regs[5]) begin
      n_fail++;
      $display("FAIL same_edge_reg5: got %h expected %h", regs_bus[5*32 +: 32], exp_regs[5]);
    end
    r_ready = 1;
    @(posedge clk);
    @(negedge clk);
    r_ready = 0;
    b_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    logic [31:0] d, got_exp;
    logic [1:0] r, got_exp_r;
    int k = 0, got = 0;
    bit ar_go, r_go;
    addrs[0] = 32'h4; addrs[1] = 32'h8; addrs[2] = 32'hC; addrs[3] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      model_read(addrs[i], d, r);
      exp_q.push_back(d);
      exp_resp_q.push_back(r);
    end
    r_ready = 1;
    ar_valid = 1;
    for (int c = 0; c < 8; c++) begin
      ar_addr = addrs[k];
      ar_go = ar_valid && ar_ready;
      r_go  = r_valid && r_ready;
      if (r_go && exp_q.size() > 0) begin
        got_exp   = exp_q.pop_front();
        got_exp_r = exp_resp_q.pop_front();
        got++;
        n_checks++;
        if (r_data !== got_exp || r_resp !== got_exp_r) begin
          n_fail++;
          $display("FAIL b2b_read%0d: got %h/%b expected %h/%b", got, r_data, r_resp, got_exp, got_exp_r);
        end
      end
      @(posedge clk);
      @(negedge clk);
      if (ar_go) k++;
      if (k == 4) begin
        ar_valid = 0;
        k = 3;
      end
    end
    ar_valid = 0;
    r_ready = 0;
    n_checks++;
    if (got != 4) begin
      n_fail++;
      $display("FAIL b2b_throughput: got %0d reads in 8 cycles expected 4", got);
    end
    exp_q.delete();
    exp_resp_q.delete();
  endtask

  task automatic test_mid_reset();
    logic [1:0] resp;
    bit to;
    int waited;
    do_write(32'h0, 32'h0BAD_0BAD, 4'hF, 0, 0, resp, to);
    aw_valid = 1; aw_addr = 32'h14;
    @(posedge clk);
    @(negedge clk);
    aw_valid = 0;
    rst_n = 0;
    #1;
    model_reset();
    n_checks++;
    if ({b_valid, r_valid, b_resp, r_resp} !== 6'b0 || r_data !== 32'h0 ||
        {aw_ready, w_ready, ar_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL midreset_outputs: got bv=%b rv=%b rdata=%h rdy=%b", b_valid, r_valid, r_data,
               {aw_ready, w_ready, ar_ready});
    end
    for (int i = 0; i < NREG; i++) begin
      n_checks++;
      if (regs_bus[i*32 +: 32] !== model_word(i)) begin
        n_fail++;
        $display("FAIL midreset_reg%0d: got %h expected %h", i, regs_bus[i*32 +: 32], model_word(i));
      end
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    w_valid = 1; w_data = 32'h7777_1234; w_strb = 4'hF; b_ready = 1;
    @(posedge clk);
    @(negedge clk);
    w_valid = 0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (b_valid !== 1'b0 || w_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_w_alone: got bv=%b wready=%b expected 0/0", b_valid, w_ready);
    end
    aw_valid = 1; aw_addr = 32'h18;
    waited = 0;
    while (b_valid !== 1'b1 && waited < 10) begin
      @(posedge clk);
      @(negedge clk);
      aw_valid = 0;
      waited++;
    end
    aw_valid = 0;
    model_write(32'h18, 32'h7777_1234, 4'hF, resp);
    n_checks++;
    if (b_valid !== 1'b1 || b_resp !== resp) begin
      n_fail++;
      $display("FAIL midreset_pair: got bv=%b bresp=%b expected 1/%b", b_valid, b_resp, resp);
    end
    @(posedge clk);
    @(negedge clk);
    b_ready = 0;
    n_checks++;
    if (regs_bus[6*32 +: 32] !== exp_regs[6]) begin
      n_fail++;
      $display("FAIL midreset_reg6: got %h expected %h", regs_bus[6*32 +: 32], exp_regs[6]);
    end
  endtask

  task automatic test_random();
    logic [31:0] addr, data, got_d, exp_d;
    logic [3:0] strb;
    logic [1:0] got_r, exp_r;
    bit to;
    for (int n = 0; n < 80; n++) begin
      addr = $urandom_range(0, 19) * 4 + $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) addr = addr | 32'h0001_0000;
      if ($urandom_range(0, 1) == 1) begin
        data = $urandom;
        strb = 4'($urandom_range(0, 15));
        do_write(addr, data, strb, $urandom_range(0, 3), $urandom_range(0, 3), got_r, to);
        model_write(addr, data, strb, exp_r);
        n_checks++;
        if (to || got_r !== exp_r) begin
          n_fail++;
          $display("FAIL rand_write%0d addr %h: got %b timeout %0d expected %b", n, addr, got_r, to, exp_r);
        end
        for (int i = 0; i < NREG; i++) begin
          n_checks++;
          if (regs_bus[i*32 +: 32] !== model_word(i)) begin
            n_fail++;
            $display("FAIL rand_reg%0d after write%0d: got %h expected %h", i, n,
                     regs_bus[i*32 +: 32], model_word(i));
          end
        end
      end else begin
        ro_data[3] = $urandom;
        model_read(addr, exp_d, exp_r);
        do_read(addr, got_d, got_r, to);
        n_checks++;
        if (to || got_d !== exp_d || got_r !== exp_r) begin
          n_fail++;
          $display("FAIL rand_read%0d addr %h: got %h/%b timeout %0d expected %h/%b",
                   n, addr, got_d, got_r, to, exp_d, exp_r);
        end
      end
    end
  endtask

  // ----------------------------------------------------------- sequence
  initial begin
    for (int i = 0; i < NREG; i++) ro_data[i] = $urandom;
    model_reset();
    test_reset();
    test_basic();
    test_w_first();
    test_read_only();
    test_decode_error();
    test_backpressure();
    test_same_edge();
    test_back_to_back();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
